pc_flow_ctrl: RTL
=================

// Module: pc_flow_ctrl
// PURPOSE
//  Control-flow sequencer for program_counter: decodes per-instruction flow flags, drives its jmp/ret_f/rom_data/ret_data.
//  Owns a hardware return-address stack (call/ret), a post-redirect fetch flush, and halt/fault parking.
//  Sits between instruction decode and the PC; the PC stays a dumb load/increment register.
// PARAMETERS
//  CNTR_WIDTH    8   PC / address width
//  STACK_DEPTH   4   return-stack entries (power of 2, >=2)
//  FLUSH_CYCLES  1   fetch slots discarded after a taken redirect (ROM latency), 1..3
//  FAULT_VEC     0   PC value parked on in FAULT
// PORTS
//  clk          in   1      clock, posedge
//  rst_n        in   1      async reset, active-low
//  instr_valid  in   1      decoded flags below are valid this cycle
//  is_jmp       in   1      jump, taken when cond_ok
//  is_call      in   1      call: push pc_in, jump to br_target
//  is_ret       in   1      return: pop, PC <= top+1
//  is_halt      in   1      halt instruction
//  cond_ok      in   1      condition result for is_jmp
//  br_target    in   CNTR   target field from instruction
//  pc_in        in   CNTR   current PC (program_counter.data_out)
//  resume       in   1      leave HALT
//  jmp          out  1      -> program_counter.jmp
//  ret_f        out  1      -> program_counter.ret_f
//  pc_tgt       out  CNTR   -> program_counter.rom_data
//  ret_data     out  CNTR   -> program_counter.ret_data (stack top)
//  stack_depth  out  log2(STACK_DEPTH)+1  occupied entries
//  discard      out  1      current fetch slot is squashed
//  halted       out  1      state HALT or FAULT
//  fault        out  1      sticky stack over/underflow
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low: clk and rst_n.
//  - Reset: state RUN, depth 0, flush_cnt 0, halted/fault/discard 0; jmp/ret_f 0; pc_tgt, ret_data 0.
//  - jmp/ret_f/pc_tgt/discard are combinational from state + inputs; PC samples them same edge (0-cycle latency).
//  - States: RUN, FLUSH, HALT, FAULT (enum in package).
//  - RUN, instr_valid=1, priority halt > ret > call > jmp (simultaneous flags resolve this way):
//    halt: jmp=1, ret_f=0, pc_tgt=pc_in; latch halt_pc=pc_in; -> HALT.
//    ret, depth>0: jmp=1, ret_f=1, ret_data=top; pop at edge; -> FLUSH.
//    call, depth<STACK_DEPTH: jmp=1, pc_tgt=br_target; push pc_in at edge; -> FLUSH.
//    jmp & cond_ok: jmp=1, pc_tgt=br_target; -> FLUSH.  jmp & !cond_ok: no action, stay RUN.
//  - RUN, instr_valid=0 or no flag: jmp=0 (PC increments).
//  - FLUSH: discard=1, jmp=0, all flags ignored; after FLUSH_CYCLES cycles -> RUN.
//  - HALT: jmp=1, pc_tgt=halt_pc each cycle (PC parked); resume=1 -> RUN with jmp=0 that cycle (PC=halt_pc+1).
//  - Underflow (ret at depth 0) or overflow (call at full, macro off): fault<=1, -> FAULT; stack unchanged.
//  - FAULT: jmp=1, pc_tgt=FAULT_VEC, halted=1; resume ignored; exit only via rst_n.
//  - ret_data = stack[top] always valid when depth>0, else 0.
//  - rst_n mid-FLUSH/HALT: immediate return to reset values; stack contents cleared.
// CONFIGURATION
//  - RAS_WRAP_EN defined: call at full overwrites oldest entry (circular), depth saturates at STACK_DEPTH, no fault.
//  - RAS_WRAP_EN undefined: call at full -> FAULT as above. Underflow faults in both builds.
// STRUCTURE
//  - pc_ctrl_pkg: state enum (RUN/FLUSH/HALT/FAULT), flag priority constants, depth-width function.
//  - Sub-module ret_addr_stack: push/pop/top/depth, wrap option; FSM + mux stay in pc_flow_ctrl.
//  - Top-level test wrapper instantiates pc_flow_ctrl + program_counter together.
// TESTING
//  - Reset: hold rst_n=0 with flags active -> jmp=0, depth=0, halted=0; release -> PC counts 0,1,2.
//  - call br_target=0x40 at pc 0x10 -> jmp=1, PC=0x40, depth=1, discard 1 cycle; later ret -> ret_f=1, PC=0x11, depth=0.
//  - is_jmp cond_ok=0 at pc 5 -> PC=6; cond_ok=1 target 0x20 -> PC=0x20, next slot discard=1 and its flags ignored.
//  - ret at depth 0 -> fault=1, PC parks at FAULT_VEC, resume no effect; rst_n clears.
//  - 5 calls with STACK_DEPTH=4: macro off -> FAULT on 5th; RAS_WRAP_EN -> depth 4, 4 rets return to calls 5,4,3,2.
//  - halt at pc 0x33 plus is_call same cycle -> HALT wins, PC holds 0x33, depth unchanged; resume -> PC=0x34.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared types for the PC flow sequencer: FSM states, the prioritised flow-op
// decode and the stack depth-counter width helper.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {StRun, StFlush, StHalt, StFault} state_e;

  // Enumerator order mirrors decode priority: halt > ret > call > jmp.
  typedef enum logic [2:0] {OpNone, OpHalt, OpRet, OpCall, OpJmp} flow_op_e;

  function automatic flow_op_e decode_op(input logic valid, input logic halt,
                                         input logic ret, input logic call,
                                         input logic jmp_taken);
    if (!valid)    return OpNone;
    if (halt)      return OpHalt;
    if (ret)       return OpRet;
    if (call)      return OpCall;
    if (jmp_taken) return OpJmp;
    return OpNone;
  endfunction

  function automatic int unsigned depth_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// Circular return-address stack with occupancy counter. With WRAP set, a push
// at full overwrites the oldest entry and the count saturates.
module ret_addr_stack
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter bit          WRAP  = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          push_data,
  output logic [WIDTH-1:0]          top,
  output logic [depth_w(DEPTH)-1:0] depth,
  output logic                      full,
  output logic                      empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned DepW = depth_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  sp_q;
  logic [PtrW-1:0]  top_idx;
  logic [DepW-1:0]  cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt_q == DepW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && (!full || WRAP);
  assign do_pop  = pop && !empty && !do_push;
  assign top_idx = sp_q - 1'b1;
  assign top     = empty ? '0 : mem_q[top_idx];
  assign depth   = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      sp_q  <= '0;
      cnt_q <= '0;
    end else if (do_push) begin
      mem_q[sp_q] <= push_data;
      sp_q        <= sp_q + 1'b1;
      if (!full) cnt_q <= cnt_q + 1'b1;
    end else if (do_pop) begin
      sp_q  <= sp_q - 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/pc_flow_ctrl.sv
// Control-flow sequencer driving program_counter: call/ret stack, post-redirect
// flush, halt and fault parking. Define RAS_WRAP_EN for a wrapping return stack.
module pc_flow_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int unsigned          CNTR_WIDTH   = 8,
  parameter int unsigned          STACK_DEPTH  = 4,
  parameter int unsigned          FLUSH_CYCLES = 1,
  parameter logic [CNTR_WIDTH-1:0] FAULT_VEC   = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            instr_valid,
  input  logic                            is_jmp,
  input  logic                            is_call,
  input  logic                            is_ret,
  input  logic                            is_halt,
  input  logic                            cond_ok,
  input  logic [CNTR_WIDTH-1:0]           br_target,
  input  logic [CNTR_WIDTH-1:0]           pc_in,
  input  logic                            resume,
  output logic                            jmp,
  output logic                            ret_f,
  output logic [CNTR_WIDTH-1:0]           pc_tgt,
  output logic [CNTR_WIDTH-1:0]           ret_data,
  output logic [depth_w(STACK_DEPTH)-1:0] stack_depth,
  output logic                            discard,
  output logic                            halted,
  output logic                            fault
);

`ifdef RAS_WRAP_EN
  localparam bit RasWrap = 1'b1;
`else
  localparam bit RasWrap = 1'b0;
`endif

  localparam logic [1:0] FlushLast = 2'(FLUSH_CYCLES - 1);

  state_e                state_q, state_d;
  logic [1:0]            flush_cnt_q, flush_cnt_d;
  logic [CNTR_WIDTH-1:0] halt_pc_q, halt_pc_d;
  logic                  fault_q, fault_d;
  logic                  push, pop, full, empty;
  flow_op_e              op;

  ret_addr_stack #(
    .WIDTH (CNTR_WIDTH),
    .DEPTH (STACK_DEPTH),
    .WRAP  (RasWrap)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_in),
    .top       (ret_data),
    .depth     (stack_depth),
    .full      (full),
    .empty     (empty)
  );

  // Gating with rst_n keeps the redirect outputs quiet while reset is held.
  assign op     = decode_op(instr_valid & rst_n, is_halt, is_ret, is_call, is_jmp & cond_ok);
  assign halted = (state_q == StHalt) || (state_q == StFault);
  assign fault  = fault_q;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    halt_pc_d   = halt_pc_q;
    fault_d     = fault_q;
    jmp         = 1'b0;
    ret_f       = 1'b0;
    pc_tgt      = '0;
    discard     = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    unique case (state_q)
      StRun: begin
        case (op)
          OpHalt: begin
            jmp       = 1'b1;
            pc_tgt    = pc_in;
            halt_pc_d = pc_in;
            state_d   = StHalt;
          end
          OpRet: begin
            if (!empty) begin
              jmp         = 1'b1;
              ret_f       = 1'b1;
              pc_tgt      = ret_data;
              pop         = 1'b1;
              flush_cnt_d = FlushLast;
              state_d     = StFlush;
            end else begin
              fault_d = 1'b1;
              state_d = StFault;
            end
          end
          OpCall: begin
            if (!full || RasWrap) begin
              jmp         = 1'b1;
              pc_tgt      = br_target;
              push        = 1'b1;
              flush_cnt_d = FlushLast;
              state_d     = StFlush;
            end else begin
              fault_d = 1'b1;
              state_d = StFault;
            end
          end
          OpJmp: begin
            jmp         = 1'b1;
            pc_tgt      = br_target;
            flush_cnt_d = FlushLast;
            state_d     = StFlush;
          end
          default: ;
        endcase
      end
      StFlush: begin
        discard = 1'b1;
        if (flush_cnt_q == '0) state_d = StRun;
        else flush_cnt_d = flush_cnt_q - 1'b1;
      end
      StHalt: begin
        if (resume) begin
          state_d = StRun;
        end else begin
          jmp    = 1'b1;
          pc_tgt = halt_pc_q;
        end
      end
      StFault: begin
        jmp    = 1'b1;
        pc_tgt = FAULT_VEC;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      flush_cnt_q <= '0;
      halt_pc_q   <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      halt_pc_q   <= halt_pc_d;
      fault_q     <= fault_d;
    end
  end

endmodule
